// File: rtl/axi_slave_response_control.sv
// ---------------------------------------------------------------------------
// axi_slave_response_control
//
// Purpose:
//    Slave-side AXI4 response generator. Drains a B-response FIFO into the
//    AXI write-response channel and an R-info / R-data FIFO pair into the
//    AXI read-data channel. Error read completions (RRESP != OKAY) carry no
//    payload, so zero-data beats are synthesized for the full burst length.
//    The B and R paths are independent state machines.
//
// Optional feature (macro AXI_SLV_RESP_TIMEOUT_EN):
//    Defined   : a TO_WIDTH-bit stall counter drives a sticky o_resp_timeout.
//    Undefined : no counter is built and o_resp_timeout is tied low.
//
// Ports:
//    i_clk, i_n_rst                    clock, asynchronous active-low reset
//    i_b_fifo_empty/bid/bresp          B-response FIFO head (first-word-fall-through)
//    o_b_fifo_read_inc                 B FIFO pop pulse
//    o_m_BVALID/BID/BRESP, i_m_BREADY  AXI write-response channel
//    i_r_info_empty/rid/rresp/len      R-info FIFO head (len = beats-1)
//    o_r_info_read_inc                 R-info FIFO pop pulse
//    i_r_data_empty, i_r_data          R-data FIFO head (first-word-fall-through)
//    o_r_data_read_inc                 R-data FIFO pop pulse
//    o_m_RVALID/RID/RDATA/RRESP/RLAST  AXI read-data channel
//    i_m_RREADY                        AXI read-data ready
//    o_resp_timeout                    sticky response-stall flag
// ---------------------------------------------------------------------------
module axi_slave_response_control #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int RESP_WIDTH = 2,
   parameter int LEN_WIDTH  = 8,
   parameter int TO_WIDTH   = 10
) (
   input  logic                  i_clk,
   input  logic                  i_n_rst,
   // B-response FIFO
   input  logic                  i_b_fifo_empty,
   input  logic [ID_WIDTH-1:0]   i_b_fifo_bid,
   input  logic [RESP_WIDTH-1:0] i_b_fifo_bresp,
   output logic                  o_b_fifo_read_inc,
   // AXI B channel
   output logic                  o_m_BVALID,
   output logic [ID_WIDTH-1:0]   o_m_BID,
   output logic [RESP_WIDTH-1:0] o_m_BRESP,
   input  logic                  i_m_BREADY,
   // R-info FIFO
   input  logic                  i_r_info_empty,
   input  logic [ID_WIDTH-1:0]   i_r_info_rid,
   input  logic [RESP_WIDTH-1:0] i_r_info_rresp,
   input  logic [LEN_WIDTH-1:0]  i_r_info_len,
   output logic                  o_r_info_read_inc,
   // R-data FIFO
   input  logic                  i_r_data_empty,
   input  logic [DATA_WIDTH-1:0] i_r_data,
   output logic                  o_r_data_read_inc,
   // AXI R channel
   output logic                  o_m_RVALID,
   output logic [ID_WIDTH-1:0]   o_m_RID,
   output logic [DATA_WIDTH-1:0] o_m_RDATA,
   output logic [RESP_WIDTH-1:0] o_m_RRESP,
   output logic                  o_m_RLAST,
   input  logic                  i_m_RREADY,
   // status
   output logic                  o_resp_timeout
);

   localparam logic [RESP_WIDTH-1:0] RESP_OKAY = '0;

   typedef enum logic [0:0] {B_IDLE, B_VALID} b_state_t;
   typedef enum logic [1:0] {R_IDLE, R_SEND, R_ERR_SEND} r_state_t;

   // ------------------------------------------------------------------------
   // B path
   // ------------------------------------------------------------------------
   b_state_t               r_b_state;
   b_state_t               w_b_state_next;
   logic [ID_WIDTH-1:0]    r_bid;
   logic [RESP_WIDTH-1:0]  r_bresp;
   logic                   w_b_hs;
   logic                   w_b_load;

   assign w_b_hs   = (r_b_state == B_VALID) & i_m_BREADY;
   // Load from idle, or reload on a handshake to sustain one response/cycle.
   // Gated by reset so no pop is issued while the FIFOs are being cleared.
   assign w_b_load = i_n_rst & ~i_b_fifo_empty & ((r_b_state == B_IDLE) | w_b_hs);

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         r_b_state <= B_IDLE;
         r_bid     <= '0;
         r_bresp   <= '0;
      end else begin
         r_b_state <= w_b_state_next;
         if (w_b_load) begin
            r_bid   <= i_b_fifo_bid;
            r_bresp <= i_b_fifo_bresp;
         end
      end
   end

   always_comb begin
      w_b_state_next = r_b_state;
      case (r_b_state)
         B_IDLE:  if (w_b_load) w_b_state_next = B_VALID;
         B_VALID: if (w_b_hs && i_b_fifo_empty) w_b_state_next = B_IDLE;
         default: w_b_state_next = B_IDLE;
      endcase
   end

   always_comb begin
      o_m_BVALID        = (r_b_state == B_VALID);
      o_m_BID           = r_bid;
      o_m_BRESP         = r_bresp;
      o_b_fifo_read_inc = w_b_load;
   end

   // ------------------------------------------------------------------------
   // R path
   // ------------------------------------------------------------------------
   r_state_t               r_r_state;
   r_state_t               w_r_state_next;
   logic [ID_WIDTH-1:0]    r_rid;
   logic [RESP_WIDTH-1:0]  r_rresp;
   logic [LEN_WIDTH-1:0]   r_len;
   logic [LEN_WIDTH-1:0]   r_beat_cnt;
   logic                   w_r_info_load;
   logic                   w_r_valid;
   logic                   w_r_hs;
   logic                   w_r_last;

   assign w_r_info_load = i_n_rst & (r_r_state == R_IDLE) & ~i_r_info_empty;
   // Valid depends only on state and FIFO occupancy, never on RREADY.
   assign w_r_valid     = ((r_r_state == R_SEND) & ~i_r_data_empty) | (r_r_state == R_ERR_SEND);
   assign w_r_hs        = w_r_valid & i_m_RREADY;
   assign w_r_last      = (r_beat_cnt == r_len);

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         r_r_state  <= R_IDLE;
         r_rid      <= '0;
         r_rresp    <= '0;
         r_len      <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_r_state <= w_r_state_next;
         if (w_r_info_load) begin
            r_rid      <= i_r_info_rid;
            r_rresp    <= i_r_info_rresp;
            r_len      <= i_r_info_len;
            r_beat_cnt <= '0;
         end else if (w_r_hs && !w_r_last) begin
            // Counter stops at len, so a full 2^LEN_WIDTH-beat burst cannot wrap.
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_r_state_next = r_r_state;
      case (r_r_state)
         R_IDLE:
            if (w_r_info_load)
               w_r_state_next = (i_r_info_rresp == RESP_OKAY) ? R_SEND : R_ERR_SEND;
         R_SEND, R_ERR_SEND:
            if (w_r_hs && w_r_last) w_r_state_next = R_IDLE;
         default: w_r_state_next = R_IDLE;
      endcase
   end

   always_comb begin
      o_m_RVALID        = w_r_valid;
      o_m_RID           = '0;
      o_m_RDATA         = '0;
      o_m_RRESP         = '0;
      o_m_RLAST         = 1'b0;
      o_r_info_read_inc = w_r_info_load;
      o_r_data_read_inc = 1'b0;
      case (r_r_state)
         R_SEND: begin
            o_m_RID           = r_rid;
            o_m_RDATA         = i_r_data;
            o_m_RRESP         = r_rresp;
            o_m_RLAST         = w_r_last;
            o_r_data_read_inc = w_r_hs;
         end
         R_ERR_SEND: begin
            // Error completions have no payload: data stays zero, no pops.
            o_m_RID   = r_rid;
            o_m_RRESP = r_rresp;
            o_m_RLAST = w_r_last;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Response-stall timeout
   // ------------------------------------------------------------------------
`ifdef AXI_SLV_RESP_TIMEOUT_EN
   logic [TO_WIDTH-1:0] r_to_cnt;
   logic [TO_WIDTH-1:0] w_to_cnt_next;
   logic                r_timeout;
   logic                w_stall;

   assign w_stall = (o_m_BVALID & ~i_m_BREADY) | (w_r_valid & ~i_m_RREADY);

   always_comb begin
      w_to_cnt_next = '0;
      // Any handshake means the master is making progress, so restart.
      if (w_stall && !(w_b_hs || w_r_hs)) begin
         w_to_cnt_next = (&r_to_cnt) ? r_to_cnt : r_to_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_to_cnt <= w_to_cnt_next;
         if (&w_to_cnt_next) r_timeout <= 1'b1;
      end
   end

   assign o_resp_timeout = r_timeout;
`else
   logic w_unused_to;
   assign w_unused_to    = TO_WIDTH[0];
   assign o_resp_timeout = 1'b0;
`endif

endmodule
